// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, widths and helpers for the serial pattern detector
//
// Purpose : FSM state encoding, datapath widths, length normalisation and
//           compare-mask helpers used by seq_det_ctrl and seq_det_core.
// Ports   : none (package).
// Options : SEQ_DET_IRQ_EN (see seq_det_ctrl) does not affect this file.
package seq_det_pkg;

  localparam int PAT_W = 12;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Lengths 0 and 13..15 are not meaningful; fold them onto the full width.
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(PAT_W)) begin
      return LEN_W'(PAT_W);
    end
    return len;
  endfunction

  // Ones in the low len bit positions.
  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i < int'(len)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// rtl/seq_det_if.sv - configuration handshake bundle for the pattern detector
//
// Purpose : groups the valid/ready configuration offer (pattern, length,
//           threshold) so producer and detector connect through modports.
// Signals : cfg_valid   producer offers a configuration
//           cfg_ready   detector accepts (only while idle)
//           cfg_pattern pattern, bit 0 = most recent serial bit
//           cfg_len     pattern length
//           cfg_thresh  match count that raises the interrupt (0 = off)
// Options : none.
interface seq_det_if;
  import seq_det_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_thresh;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_thresh,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_thresh,
    output cfg_ready
  );

endinterface

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - history shift register and masked pattern compare
//
// Purpose : holds the recent serial bits and reports whether the history,
//           including the bit being shifted in this cycle, matches the
//           low len bits of the pattern.
// Ports   : clk        clock
//           reset      synchronous active-low reset
//           clr_i      clear history (start of a detection run)
//           shift_i    shift bit_i into history at bit 0
//           bit_i      incoming serial bit
//           pattern_i  pattern to compare against
//           len_i      normalised pattern length (1..12)
//           hit_o      updated history matches pattern (unqualified)
// Options : none.
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_d;
  logic [PAT_W-1:0] hist_shift;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_i};
    hist_d     = hist_q;
    if (clr_i) begin
      hist_d = '0;
    end else if (shift_i) begin
      hist_d = hist_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Compare the post-shift value so the completing bit is matched in the
  // same cycle it arrives; the controller registers the result.
  assign hit_o = ((hist_shift ^ pattern_i) & len_mask(len_i)) == '0;

endmodule

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - serial pattern detector controller (FSM, counters, irq)
//
// Purpose : accepts a pattern configuration while idle, then on start fills
//           the history and reports overlapping matches on the serial input.
// Ports   : clk        clock
//           reset      synchronous active-low reset
//           cfg        configuration handshake (seq_det_if.slave)
//           start      begin detection (needs a loaded configuration)
//           stop       end detection; beats start and a same-cycle match
//           x_i        serial data bit
//           x_valid    qualifier for x_i
//           irq_clr    clears irq_o
//           det_o      one-cycle match pulse, one cycle after the bit
//           busy       high while filling or running
//           match_cnt  matches since last start, saturating
//           irq_o      sticky threshold interrupt
// Options : SEQ_DET_IRQ_EN - when defined, irq_o is set as match_cnt reaches
//           the nonzero threshold; when undefined irq_o is tied low.
module seq_det_ctrl
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  seq_det_if.slave         cfg,
  input  logic             start,
  input  logic             stop,
  input  logic             x_i,
  input  logic             x_valid,
  input  logic             irq_clr,
  output logic             det_o,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq_o
);

  state_e           state_q, state_d;
  logic             loaded_q, loaded_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             det_q, det_d;

  logic             cfg_fire;
  logic             start_ok;
  logic             bit_ok;
  logic [LEN_W-1:0] fill_inc;
  logic             to_run;
  logic             hit;
  logic             match;

  assign cfg_fire = cfg.cfg_valid && (state_q == IDLE);
  assign start_ok = (state_q == IDLE) && start && loaded_q && !stop;
  assign bit_ok   = (state_q != IDLE) && x_valid && !stop;
  assign fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
  assign to_run   = (state_q == FILL) && bit_ok && (fill_inc >= len_q);
  // The bit that completes the fill is already compared.
  assign match    = bit_ok && ((state_q == RUN) || to_run) && hit;

  seq_det_core u_core (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (start_ok),
    .shift_i   (bit_ok),
    .bit_i     (x_i),
    .pattern_i (pat_q),
    .len_i     (len_q),
    .hit_o     (hit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = FILL;
      FILL:    if (stop) state_d = IDLE; else if (to_run) state_d = RUN;
      RUN:     if (stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy          = (state_q != IDLE);
    cfg.cfg_ready = (state_q == IDLE);
  end

  // Datapath next-state
  always_comb begin
    loaded_d = loaded_q;
    pat_d    = pat_q;
    len_d    = len_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    det_d    = match;
    if (cfg_fire) begin
      pat_d    = cfg.cfg_pattern;
      len_d    = norm_len(cfg.cfg_len);
      loaded_d = 1'b1;
    end
    if (start_ok) begin
      fill_d = '0;
      cnt_d  = '0;
    end else if (bit_ok) begin
      fill_d = fill_inc;
    end
    if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      loaded_q <= 1'b0;
      pat_q    <= '0;
      len_q    <= LEN_W'(PAT_W);
      fill_q   <= '0;
      cnt_q    <= '0;
      det_q    <= 1'b0;
    end else begin
      loaded_q <= loaded_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      det_q    <= det_d;
    end
  end

  assign det_o     = det_q;
  assign match_cnt = cnt_q;

`ifdef SEQ_DET_IRQ_EN
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             irq_q, irq_d;
  logic             irq_set;

  always_comb begin
    thresh_d = cfg_fire ? cfg.cfg_thresh : thresh_q;
    // Fire only on the increment that lands on the threshold, not while
    // the count merely sits there (e.g. saturated).
    irq_set  = (cnt_d != cnt_q) && (cnt_d == thresh_q) && (thresh_q != '0);
    irq_d    = irq_set | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{cfg.cfg_thresh, irq_clr};
  assign irq_o = 1'b0;
`endif

endmodule
